ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Pipelined carrier and checker for the decoded control bundle. Takes the `DX_ctrl` word the decoder produces in ID and carries it through the D/X, X/M and M/W pipeline registers, splitting off `X_ctrl`, `M_ctrl` and `WB_ctrl` at each stage. It detects load-use hazards and generates ID stall, squashes wrong-path instructions on taken branch/jump, and produces EX forwarding selects. It sits between the decoder and the datapath pipeline registers.

## Interface
- `CNT_W`, default 16: width of the saturating stall and flush event counters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_ctrl`  in  DX_ctrl  decoded bundle for the instruction in ID.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register fields of the ID instruction.
- `m_zero`  in  1  ALU zero flag registered alongside the X/M stage.
- `x_ctrl`  out  X_ctrl  EX controls from D/X.
- `m_ctrl`  out  M_ctrl  MEM controls from X/M.
- `wb_ctrl`  out  WB_ctrl  WB controls from M/W.
- `x_rs`, `x_rt`  out  5 each  source registers in D/X.
- `m_dest`, `w_dest`  out  5 each  resolved destination in X/M and in M/W.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `flush`  out  1  squash IF/ID this cycle.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 regfile, 10 X/M result, 01 M/W result.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  event counters.

## Operation
- Stage registers are D/X (bundle, rs, rt, rd, valid), X/M (XM bundle, dest, valid) and M/W (MW bundle, dest, valid).
- A bubble is an all-zero bundle with valid=0. All enables in a bubble are DISABLE.
- dest resolves on the D/X→X/M transfer: reg_dst ? rd : rt.
- **Load-use.** stall=1 when all of the following hold:
  - D/X is valid with read_mem=1;
  - its rt ≠ 0;
  - rt equals id_rs or id_rt;
  - id_valid=1.
- **On stall:** D/X loads a bubble. X/M and M/W advance normally. The upstream stage holds IF/ID.
- **Taken redirect.** taken = X/M valid and (jmp or (branch and m_zero)). When taken, flush=1:
  - D/X loads a bubble (the ID instruction is discarded);
  - X/M loads a bubble (the current D/X instruction is discarded).
- **flush has priority over stall.** When both conditions hold, stall is driven 0.
- **Forwarding.** fwd_a is derived for x_rs and fwd_b for x_rt:
  - 10 if X/M is valid, reg_write=1, m_dest ≠ 0 and m_dest matches;
  - otherwise 01 if M/W is valid, reg_write=1, w_dest ≠ 0 and w_dest matches;
  - otherwise 00.
  - Register 0 never forwards.
- **Counters.** stall_cnt increments on each cycle with stall=1. flush_cnt increments on each cycle with flush=1. Both saturate at all-ones.
- With id_valid=0, D/X loads a bubble.

## Timing
- Each stage has 1-cycle latency. A bundle presented in ID at cycle n:
  - appears on x_ctrl at n+1;
  - on m_ctrl at n+2;
  - on wb_ctrl at n+3.
- stall, flush, fwd_a and fwd_b are combinational from current stage state and ID inputs. They have no registered delay.
- A load followed directly by a dependent instruction costs exactly 1 stall cycle. On the next cycle fwd selects 01 (M/W).
- A taken branch or jump costs 2 squashed slots.
- **Reset.** On any clock edge with reset=1, reset overrides stall and flush mid-operation:
  - all valids, bundles and dest fields clear to 0;
  - both counters clear to 0.
- **Outputs in the cycle after reset:**
  - x_ctrl, m_ctrl and wb_ctrl are 0;
  - stall, flush, fwd_a and fwd_b are 0.

## Configuration
- `CTRL_PIPE_FPU_EN` defined:
  - fpu_write, fpu_to_mem and fpu_to_wb propagate unchanged;
  - a load with fpu_write=1 (LWC1) is excluded from the GPR load-use check;
  - an FP destination is never a GPR forwarding source.
- Undefined:
  - the three FPU bits are forced to DISABLE on entry to D/X;
  - the downstream FPU paths stay idle.

## Structure
- These belong in the shared `definitions` package:
  - the struct types DX_ctrl, XM_ctrl, MW_ctrl, X_ctrl, M_ctrl and WB_ctrl;
  - Signal, ENABLE and DISABLE;
  - the forward-select localparams FWD_RF=2'b00, FWD_XM=2'b10 and FWD_MW=2'b01.
- One sub-module, `hazard_unit`, holds the combinational stall/flush/forwarding logic. `ctrl_pipe` holds the registers and counters.

## Test plan
- Reset held 3 cycles mid-stream, then released → all ctrl outputs, stall, flush, fwd and counters read 0.
- LW writing r5, then ADD reading r5 → stall=1 for exactly 1 cycle; a bubble appears on x_ctrl; the ADD reaches EX with fwd_a=01; stall_cnt=1.
- ADDI writing r3, then ADD with rs=r3 and rt=r3 → fwd_a=fwd_b=10 in the ADD's EX cycle; with the write to r0 instead → both 00.
- BEQ with m_zero=1 → flush=1 for one cycle; the next two x_ctrl/m_ctrl slots are bubbles; flush_cnt=1. With m_zero=0 → no flush.
- Load-use stall condition in the same cycle as a J in X/M → flush=1, stall=0.
- With CTRL_PIPE_FPU_EN: LWC1 to f5, then ADD reading r5 → no stall and fpu_write=1 reaches wb_ctrl. Without the macro → wb_ctrl.fpu_write=0.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle types, enable levels and forwarding-select codes.
// Latency: none (types and constants only).
// Backpressure: none. Build macro CTRL_PIPE_FPU_EN enables the FPU control paths.
package definitions;

  typedef logic Signal;

  localparam Signal ENABLE  = 1'b1;
  localparam Signal DISABLE = 1'b0;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_XM = 2'b10;
  localparam logic [1:0] FWD_MW = 2'b01;

`ifdef CTRL_PIPE_FPU_EN
  localparam bit FPU_EN = 1'b1;
`else
  localparam bit FPU_EN = 1'b0;
`endif

  typedef struct packed {
    Signal       reg_dst;
    Signal       alu_src;
    logic [2:0]  alu_op;
  } X_ctrl;

  typedef struct packed {
    Signal read_mem;
    Signal write_mem;
    Signal branch;
    Signal jmp;
    Signal fpu_to_mem;
  } M_ctrl;

  typedef struct packed {
    Signal reg_write;
    Signal mem_to_reg;
    Signal fpu_write;
    Signal fpu_to_wb;
  } WB_ctrl;

  typedef struct packed {
    X_ctrl  x;
    M_ctrl  m;
    WB_ctrl wb;
  } DX_ctrl;

  typedef struct packed {
    M_ctrl  m;
    WB_ctrl wb;
  } XM_ctrl;

  typedef struct packed {
    WB_ctrl wb;
  } MW_ctrl;

  // Without the FPU build the three FPU enables are held at DISABLE so the
  // downstream FP paths never see activity.
  function automatic DX_ctrl fpu_gate(input DX_ctrl c);
    DX_ctrl r;
    r = c;
    r.wb.fpu_write  = c.wb.fpu_write  & FPU_EN;
    r.wb.fpu_to_wb  = c.wb.fpu_to_wb  & FPU_EN;
    r.m.fpu_to_mem  = c.m.fpu_to_mem  & FPU_EN;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Load-use stall, taken-redirect flush and EX operand forwarding selects.
// Latency: purely combinational from stage state and ID fields.
// Backpressure: produces the stall; flush wins over stall. FP loads/writers excluded under CTRL_PIPE_FPU_EN.
module hazard_unit
  import definitions::*;
(
  input  logic       dx_valid,
  input  logic       dx_read_mem,
  input  logic       dx_fpu_write,
  input  logic [4:0] dx_rs,
  input  logic [4:0] dx_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       xm_valid,
  input  logic       xm_jmp,
  input  logic       xm_branch,
  input  logic       xm_reg_write,
  input  logic       xm_fpu_write,
  input  logic       m_zero,
  input  logic [4:0] m_dest,
  input  logic       mw_valid,
  input  logic       mw_reg_write,
  input  logic       mw_fpu_write,
  input  logic [4:0] w_dest,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic taken;
  logic load_use;
  logic xm_src;
  logic mw_src;

  // Redirect squashes the two younger slots; a stall in the same cycle is moot.
  always_comb begin
    taken    = xm_valid & (xm_jmp | (xm_branch & m_zero));
    load_use = dx_valid & dx_read_mem & ~(FPU_EN & dx_fpu_write) &
               (dx_rt != 5'd0) & ((dx_rt == id_rs) | (dx_rt == id_rt)) & id_valid;
    flush    = taken;
    stall    = load_use & ~taken;
  end

  // Nearest producer wins; r0 and FP destinations never act as GPR sources.
  always_comb begin
    xm_src = xm_valid & xm_reg_write & ~(FPU_EN & xm_fpu_write) & (m_dest != 5'd0);
    mw_src = mw_valid & mw_reg_write & ~(FPU_EN & mw_fpu_write) & (w_dest != 5'd0);
    fwd_a  = (xm_src && m_dest == dx_rs) ? FWD_XM :
             (mw_src && w_dest == dx_rs) ? FWD_MW : FWD_RF;
    fwd_b  = (xm_src && m_dest == dx_rt) ? FWD_XM :
             (mw_src && w_dest == dx_rt) ? FWD_MW : FWD_RF;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control bundle through D/X, X/M and M/W with stall/flush handling.
// Latency: 1 cycle per stage (x_ctrl n+1, m_ctrl n+2, wb_ctrl n+3).
// Backpressure: stall bubbles D/X while upstream holds IF/ID; flush bubbles D/X and X/M. CTRL_PIPE_FPU_EN enables FPU bits.
module ctrl_pipe
  import definitions::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  DX_ctrl           id_ctrl,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             m_zero,
  output X_ctrl            x_ctrl,
  output M_ctrl            m_ctrl,
  output WB_ctrl           wb_ctrl,
  output logic [4:0]       x_rs,
  output logic [4:0]       x_rt,
  output logic [4:0]       m_dest,
  output logic [4:0]       w_dest,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  DX_ctrl     dx_c;
  logic       dx_v;
  logic [4:0] dx_rs, dx_rt, dx_rd;
  XM_ctrl     xm_c;
  logic       xm_v;
  logic [4:0] xm_dest;
  MW_ctrl     mw_c;
  logic       mw_v;
  logic [4:0] mw_dest;

  hazard_unit u_hazard (
    .dx_valid     (dx_v),
    .dx_read_mem  (dx_c.m.read_mem),
    .dx_fpu_write (dx_c.wb.fpu_write),
    .dx_rs        (dx_rs),
    .dx_rt        (dx_rt),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .xm_valid     (xm_v),
    .xm_jmp       (xm_c.m.jmp),
    .xm_branch    (xm_c.m.branch),
    .xm_reg_write (xm_c.wb.reg_write),
    .xm_fpu_write (xm_c.wb.fpu_write),
    .m_zero       (m_zero),
    .m_dest       (xm_dest),
    .mw_valid     (mw_v),
    .mw_reg_write (mw_c.wb.reg_write),
    .mw_fpu_write (mw_c.wb.fpu_write),
    .w_dest       (mw_dest),
    .stall        (stall),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // D/X: bubble on stall, flush or empty ID slot; otherwise take the ID bundle.
  always_ff @(posedge clk) begin
    if (reset || flush || stall || !id_valid) begin
      dx_c  <= '0;
      dx_v  <= 1'b0;
      dx_rs <= 5'd0;
      dx_rt <= 5'd0;
      dx_rd <= 5'd0;
    end else begin
      dx_c  <= fpu_gate(id_ctrl);
      dx_v  <= 1'b1;
      dx_rs <= id_rs;
      dx_rt <= id_rt;
      dx_rd <= id_rd;
    end
  end

  // X/M: destination resolves here; a redirect discards the D/X instruction.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      xm_c    <= '0;
      xm_v    <= 1'b0;
      xm_dest <= 5'd0;
    end else begin
      xm_c    <= '{m: dx_c.m, wb: dx_c.wb};
      xm_v    <= dx_v;
      xm_dest <= dx_c.x.reg_dst ? dx_rd : dx_rt;
    end
  end

  // M/W: always advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      mw_c    <= '0;
      mw_v    <= 1'b0;
      mw_dest <= 5'd0;
    end else begin
      mw_c    <= '{wb: xm_c.wb};
      mw_v    <= xm_v;
      mw_dest <= xm_dest;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign x_ctrl  = dx_c.x;
  assign m_ctrl  = xm_c.m;
  assign wb_ctrl = mw_c.wb;
  assign x_rs    = dx_rs;
  assign x_rt    = dx_rt;
  assign m_dest  = xm_dest;
  assign w_dest  = mw_dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized and directed checks of ctrl_pipe against an instruction-level model.
// Latency: model advances one instruction slot per clock.
// Backpressure: fetch model re-presents the ID instruction when a stall is expected.
module tb_ctrl_pipe;
  import definitions::*;

  localparam int CNT_W = 16;
`ifdef CTRL_PIPE_FPU_EN
  localparam bit FPU = 1'b1;
`else
  localparam bit FPU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  DX_ctrl           id_ctrl;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             m_zero;
  X_ctrl            x_ctrl;
  M_ctrl            m_ctrl;
  WB_ctrl           wb_ctrl;
  logic [4:0]       x_rs, x_rt, m_dest, w_dest;
  logic             stall, flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .m_zero(m_zero),
    .x_ctrl(x_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
    .x_rs(x_rs), .x_rt(x_rt), .m_dest(m_dest), .w_dest(w_dest),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level model: one record per in-flight instruction slot.
  typedef struct {
    logic       v;
    DX_ctrl     c;
    logic [4:0] rs, rt, rd;
  } ins_t;

  ins_t ex, mem, wb;
  ins_t bub = '{v: 1'b0, c: '0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
  int   m_scnt, m_fcnt;
  logic mdl_stall;

  logic       obs_stall, obs_flush;
  logic [1:0] obs_fa, obs_fb;
  X_ctrl      obs_x;
  M_ctrl      obs_m;
  WB_ctrl     obs_wb;
  logic [4:0] obs_mdest;
  int         obs_scnt, obs_fcnt;

  function automatic logic [4:0] dest_of(input ins_t i);
    if (!i.v) return 5'd0;
    return i.c.x.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic logic gpr_writer(input ins_t i, input logic [4:0] r);
    return i.v && i.c.wb.reg_write && !(FPU && i.c.wb.fpu_write) && dest_of(i) == r;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (gpr_writer(mem, r)) return 2'b10;
    if (gpr_writer(wb, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic cyc(input DX_ctrl c, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic z, input logic rst);
    logic taken, lu, e_stall;
    ins_t nin;
    id_ctrl = c; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; m_zero = z; reset = rst;
    @(negedge clk);
    taken   = mem.v && (mem.c.m.jmp || (mem.c.m.branch && z));
    lu      = v && ex.v && ex.c.m.read_mem && !(FPU && ex.c.wb.fpu_write) &&
              ex.rt != 5'd0 && (ex.rt == rs || ex.rt == rt);
    e_stall = lu && !taken;
    mdl_stall = e_stall;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(taken));
    chk("fwd_a", 32'(fwd_a), 32'(fwd_of(ex.rs)));
    chk("fwd_b", 32'(fwd_b), 32'(fwd_of(ex.rt)));
    chk("x_ctrl", 32'(x_ctrl), 32'(ex.c.x));
    chk("m_ctrl", 32'(m_ctrl), 32'(mem.c.m));
    chk("wb_ctrl", 32'(wb_ctrl), 32'(wb.c.wb));
    chk("x_rs", 32'(x_rs), 32'(ex.rs));
    chk("x_rt", 32'(x_rt), 32'(ex.rt));
    chk("m_dest", 32'(m_dest), 32'(dest_of(mem)));
    chk("w_dest", 32'(w_dest), 32'(dest_of(wb)));
    chk("stall_cnt", 32'(stall_cnt), m_scnt);
    chk("flush_cnt", 32'(flush_cnt), m_fcnt);
    obs_stall = stall; obs_flush = flush; obs_fa = fwd_a; obs_fb = fwd_b;
    obs_x = x_ctrl; obs_m = m_ctrl; obs_wb = wb_ctrl; obs_mdest = m_dest;
    obs_scnt = int'(stall_cnt); obs_fcnt = int'(flush_cnt);
    @(posedge clk);
    if (rst) begin
      ex = bub; mem = bub; wb = bub; m_scnt = 0; m_fcnt = 0;
    end else begin
      nin.v = 1'b1; nin.c = c; nin.rs = rs; nin.rt = rt; nin.rd = rd;
      if (!FPU) begin
        nin.c.wb.fpu_write = 1'b0; nin.c.wb.fpu_to_wb = 1'b0; nin.c.m.fpu_to_mem = 1'b0;
      end
      wb  = mem;
      mem = taken ? bub : ex;
      ex  = (taken || e_stall || !v) ? bub : nin;
      if (e_stall && m_scnt < (1 << CNT_W) - 1) m_scnt++;
      if (taken && m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
    end
    #1;
  endtask

  task automatic nop();
    cyc('0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic DX_ctrl mk(input bit rdst, input bit rw, input bit rm, input bit wm,
                                input bit br, input bit j, input bit fw);
    DX_ctrl c;
    c = '0;
    c.x.reg_dst = rdst; c.x.alu_src = !rdst; c.x.alu_op = 3'd2;
    c.m.read_mem = rm; c.m.write_mem = wm; c.m.branch = br; c.m.jmp = j;
    c.wb.reg_write = rw; c.wb.mem_to_reg = rm; c.wb.fpu_write = fw; c.wb.fpu_to_wb = fw;
    return c;
  endfunction

  DX_ctrl LW, ADD, ADDI, SW, BEQ, JMP, LWC1;
  DX_ctrl cur;
  logic   cv;
  logic [4:0] crs, crt, crd;
  logic [31:0] rnd;
  logic   need_new;

  initial begin
    LW   = mk(0, 1, 1, 0, 0, 0, 0);
    ADD  = mk(1, 1, 0, 0, 0, 0, 0);
    ADDI = mk(0, 1, 0, 0, 0, 0, 0);
    SW   = mk(0, 0, 0, 1, 0, 0, 0);
    BEQ  = mk(0, 0, 0, 0, 1, 0, 0);
    JMP  = mk(0, 0, 0, 0, 0, 1, 0);
    LWC1 = mk(0, 0, 1, 0, 0, 0, 1);
    ex = bub; mem = bub; wb = bub; m_scnt = 0; m_fcnt = 0;
    reset = 1'b1; id_ctrl = '0; id_valid = 1'b0; id_rs = 0; id_rt = 0; id_rd = 0; m_zero = 0;
    repeat (3) @(posedge clk);
    #1;

    // Random stream with a fetch model that holds the ID slot across stalls.
    need_new = 1'b1;
    cur = '0; cv = 1'b0; crs = 0; crt = 0; crd = 0;
    for (int i = 0; i < 800; i++) begin
      if (need_new) begin
        rnd = $urandom;
        cur = rnd[$bits(DX_ctrl)-1:0];
        cur.m.jmp      = ($urandom_range(0, 11) == 0);
        cur.m.branch   = ($urandom_range(0, 5) == 0);
        cur.m.read_mem = ($urandom_range(0, 2) == 0);
        cv  = ($urandom_range(0, 7) != 0);
        crs = 5'($urandom_range(0, 7));
        crt = 5'($urandom_range(0, 7));
        crd = 5'($urandom_range(0, 7));
      end
      cyc(cur, cv, crs, crt, crd, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
      need_new = !mdl_stall;
    end

    // Reset held 3 cycles mid-stream.
    cyc(LW, 1, 1, 5, 0, 0, 0);
    repeat (3) cyc(ADD, 1, 5, 5, 6, 1, 1);
    nop();
    chk("rst_x", 32'(obs_x), 0);  chk("rst_m", 32'(obs_m), 0);  chk("rst_wb", 32'(obs_wb), 0);
    chk("rst_stall", 32'(obs_stall), 0); chk("rst_flush", 32'(obs_flush), 0);
    chk("rst_fwd_a", 32'(obs_fa), 0); chk("rst_fwd_b", 32'(obs_fb), 0);
    chk("rst_scnt", obs_scnt, 0); chk("rst_fcnt", obs_fcnt, 0);

    // Load-use: one stall, bubble in EX, then M/W forwarding.
    cyc(LW, 1, 1, 5, 0, 0, 0);
    cyc(ADD, 1, 5, 2, 7, 0, 0);  chk("lu_stall", 32'(obs_stall), 1);
    cyc(ADD, 1, 5, 2, 7, 0, 0);  chk("lu_stall_once", 32'(obs_stall), 0);
                                 chk("lu_bubble", 32'(obs_x), 0);
    nop();                       chk("lu_fwd_a", 32'(obs_fa), 32'(2'b01));
                                 chk("lu_scnt", obs_scnt, 1);

    // X/M forwarding, then r0 never forwards.
    cyc(ADDI, 1, 1, 3, 0, 0, 0);
    cyc(ADD, 1, 3, 3, 9, 0, 0);
    nop();                       chk("xm_fwd_a", 32'(obs_fa), 32'(2'b10));
                                 chk("xm_fwd_b", 32'(obs_fb), 32'(2'b10));
                                 chk("xm_dest", 32'(obs_mdest), 3);
    cyc(ADDI, 1, 1, 0, 0, 0, 0);
    cyc(ADD, 1, 0, 0, 9, 0, 0);
    nop();                       chk("r0_fwd_a", 32'(obs_fa), 0);
                                 chk("r0_fwd_b", 32'(obs_fb), 0);

    // Taken branch squashes two slots.
    cyc(BEQ, 1, 1, 2, 0, 0, 0);
    cyc(SW, 1, 1, 2, 0, 0, 0);
    cyc(SW, 1, 1, 2, 0, 1, 0);   chk("br_flush", 32'(obs_flush), 1);
    cyc(SW, 1, 1, 2, 0, 0, 0);   chk("br_flush_once", 32'(obs_flush), 0);
                                 chk("br_x_bub", 32'(obs_x), 0);
                                 chk("br_m_bub1", 32'(obs_m), 0);
    nop();                       chk("br_m_bub2", 32'(obs_m), 0);
                                 chk("br_fcnt", obs_fcnt, 1);
    // Not taken.
    cyc(BEQ, 1, 1, 2, 0, 0, 0);
    cyc(SW, 1, 1, 2, 0, 0, 0);
    cyc(SW, 1, 1, 2, 0, 0, 0);   chk("bnt_flush", 32'(obs_flush), 0);
    nop(); nop();

    // Jump in X/M while a load-use hazard is present: flush wins.
    cyc(JMP, 1, 0, 0, 0, 0, 0);
    cyc(LW, 1, 1, 5, 0, 0, 0);
    cyc(ADD, 1, 5, 2, 7, 0, 0);  chk("j_lu_flush", 32'(obs_flush), 1);
                                 chk("j_lu_stall", 32'(obs_stall), 0);
    nop(); nop(); nop();

    // FP load to f5 followed by a GPR read of r5.
    cyc(LWC1, 1, 1, 5, 0, 0, 0);
    cyc(ADD, 1, 5, 2, 7, 0, 0);  chk("fp_stall", 32'(obs_stall), FPU ? 1 - 1 : 1);
    cyc(ADD, 1, 5, 2, 7, 0, 0);
    nop();                       chk("fp_wb_write", 32'(obs_wb.fpu_write), FPU ? 1 : 0);
    nop(); nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
